// File: rtl/bpsk_phase_sequencer_if.sv
// Bit handshake between the bit source (framer/FIFO) and the BPSK phase sequencer.
// master: bit source, slave: sequencer.
interface bpsk_phase_sequencer_if;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;

  modport master (
    output bit_in,
    output bit_valid,
    input  bit_ready
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    output bit_ready
  );
endinterface

// File: rtl/bpsk_phase_sequencer.sv
// BPSK phase sequencer: steps the sine table index once every CLK_PER_SAMPLE clocks
// and adds a half-table (180 deg) offset while the current symbol bit is 1.
// One bit is taken per symbol of SINE_RESOLUTION*CYCLES_PER_BIT*CLK_PER_SAMPLE clocks.
// Optional macro BPSK_DIFF_ENC_EN: differential encoding, cur_bit = bit_in ^ prev_sym.
// SINE_RESOLUTION must be even and >= 2, CLK_PER_SAMPLE and CYCLES_PER_BIT >= 1.
//
// state | meaning
// IDLE  | no symbol in progress, phase held at 0, ready when en=1
// TX    | symbol in progress, index advancing, ready only on the symbol-end clock
module bpsk_phase_sequencer #(
  parameter int DATA_WIDTH      = 12,
  parameter int SINE_RESOLUTION = 20,
  parameter int CLK_PER_SAMPLE  = 4,
  parameter int CYCLES_PER_BIT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  bpsk_phase_sequencer_if.slave     bit_bus,
  output logic [DATA_WIDTH-1:0]     phase,
  output logic                      sample_strobe,
  output logic                      symbol_start,
  output logic                      active,
  output logic                      underrun
);

  localparam int IDX_W = (SINE_RESOLUTION > 2) ? $clog2(SINE_RESOLUTION) : 1;
  localparam int DIV_W = (CLK_PER_SAMPLE > 2) ? $clog2(CLK_PER_SAMPLE) : 1;
  localparam int CAR_W = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SINE_RESOLUTION - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_SAMPLE - 1);
  localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W:0]   HALF     = (IDX_W + 1)'(SINE_RESOLUTION / 2);
  localparam logic [IDX_W:0]   FULL     = (IDX_W + 1)'(SINE_RESOLUTION);

  typedef enum logic {
    IDLE = 1'b0,
    TX   = 1'b1
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  logic [CAR_W-1:0] car_cnt;
  logic             cur_bit;
`ifdef BPSK_DIFF_ENC_EN
  logic             prev_sym;
`endif

  logic             tick;
  logic             sym_end;
  logic             ready_int;
  logic             xfer;
  logic             bit_eff;
  logic [IDX_W-1:0] idx_next;

  // Table index with the 180 deg offset applied, wrapped back into the table.
  function automatic logic [DATA_WIDTH-1:0] phase_of(input logic [IDX_W-1:0] i, input logic b);
    logic [IDX_W:0] s;
    s = {1'b0, i} + (b ? HALF : '0);
    if (s >= FULL) s = s - FULL;
    return DATA_WIDTH'(s);
  endfunction

  // Tick, symbol-end and handshake decode; ready is held low while rst is asserted
  // so a bit offered during reset is never consumed.
  always_comb begin
    tick      = (state == TX) && (div_cnt == DIV_LAST);
    sym_end   = tick && (idx == IDX_LAST) && (car_cnt == CAR_LAST);
    ready_int = !rst && en && ((state == IDLE) || sym_end);
    xfer      = ready_int && bit_bus.bit_valid;
    idx_next  = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
`ifdef BPSK_DIFF_ENC_EN
    bit_eff   = bit_bus.bit_in ^ prev_sym;
`else
    bit_eff   = bit_bus.bit_in;
`endif
  end

  assign bit_bus.bit_ready = ready_int;

  // Sequencer FSM with registered phase and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      div_cnt       <= '0;
      idx           <= '0;
      car_cnt       <= '0;
      cur_bit       <= 1'b0;
      phase         <= '0;
      sample_strobe <= 1'b0;
      symbol_start  <= 1'b0;
      active        <= 1'b0;
      underrun      <= 1'b0;
`ifdef BPSK_DIFF_ENC_EN
      prev_sym      <= 1'b0;
`endif
    end else begin
      sample_strobe <= 1'b0;
      symbol_start  <= 1'b0;
      underrun      <= 1'b0;
      case (state)
        IDLE: begin
          phase  <= '0;
          active <= 1'b0;
          if (xfer) begin
            state        <= TX;
            cur_bit      <= bit_eff;
`ifdef BPSK_DIFF_ENC_EN
            prev_sym     <= bit_eff;
`endif
            div_cnt      <= '0;
            idx          <= '0;
            car_cnt      <= '0;
            phase        <= phase_of('0, bit_eff);
            symbol_start <= 1'b1;
            active       <= 1'b1;
          end
        end
        TX: begin
          if (!tick) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt       <= '0;
            sample_strobe <= 1'b1;
            if (sym_end) begin
              idx     <= '0;
              car_cnt <= '0;
              if (xfer) begin
                // Back-to-back symbol: no gap clock, next clock is index 0 of the new bit.
                cur_bit      <= bit_eff;
`ifdef BPSK_DIFF_ENC_EN
                prev_sym     <= bit_eff;
`endif
                phase        <= phase_of('0, bit_eff);
                symbol_start <= 1'b1;
              end else begin
                state    <= IDLE;
                phase    <= '0;
                active   <= 1'b0;
                underrun <= en;
`ifdef BPSK_DIFF_ENC_EN
                prev_sym <= 1'b0;
`endif
              end
            end else begin
              idx   <= idx_next;
              phase <= phase_of(idx_next, cur_bit);
              if (idx == IDX_LAST) car_cnt <= car_cnt + CAR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_phase_sequencer.sv
// Directed bench for bpsk_phase_sequencer with default parameters (20 entries,
// 4 clocks per step, 2 carrier periods per bit => 160-clock symbols).
module tb_bpsk_phase_sequencer;
  localparam int SYM_CLKS = 160;
`ifdef BPSK_DIFF_ENC_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] phase;
  logic        sample_strobe;
  logic        symbol_start;
  logic        active;
  logic        underrun;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  bpsk_phase_sequencer_if bus ();

  bpsk_phase_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .bit_bus       (bus),
    .phase         (phase),
    .sample_strobe (sample_strobe),
    .symbol_start  (symbol_start),
    .active        (active),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && bus.bit_valid && bus.bit_ready) xfers++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_clk();
    @(posedge clk);
    #1;
  endtask

  // Walks one symbol from its first clock, checking every clock against the
  // expected index sequence for bit b.
  task automatic run_symbol(input logic b, input logic strobe_first, input logic end_ready,
                            input int drop_at, input int n_clk);
    int ph;
    for (int k = 1; k <= n_clk; k++) begin
      if (k > 1) next_clk();
      if (k == drop_at) en = 1'b0;
      #1;
      ph = ((k - 1) / 4) % 20 + (b ? 10 : 0);
      if (ph >= 20) ph = ph - 20;
      check_val("sym_phase", 32'(phase), 32'(ph));
      check_val("sym_active", 32'(active), 32'd1);
      check_val("sym_start", 32'(symbol_start), 32'(k == 1));
      check_val("sym_strobe", 32'(sample_strobe), (k == 1) ? 32'(strobe_first) : 32'((k - 1) % 4 == 0));
      check_val("sym_ready", 32'(bus.bit_ready), 32'((k == SYM_CLKS) && end_ready));
      check_val("sym_underrun", 32'(underrun), 32'd0);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_underrun, input logic exp_ready);
    check_val({tag, "_active"}, 32'(active), 32'd0);
    check_val({tag, "_phase"}, 32'(phase), 32'd0);
    check_val({tag, "_underrun"}, 32'(underrun), 32'(exp_underrun));
    check_val({tag, "_ready"}, 32'(bus.bit_ready), 32'(exp_ready));
    check_val({tag, "_start"}, 32'(symbol_start), 32'd0);
  endtask

  // Back-to-back stream with bit_valid held high; the next bit is presented on
  // the first clock of each symbol and valid drops during the last one.
  task automatic run_stream(input logic [3:0] bits);
    logic prev;
    logic cur;
    int   x0;
    prev = 1'b0;
    x0   = xfers;
    bus.bit_in    = bits[0];
    bus.bit_valid = 1'b1;
    next_clk();
    for (int i = 0; i < 4; i++) begin
      cur  = DIFF ? (bits[i] ^ prev) : bits[i];
      prev = cur;
      if (i < 3) bus.bit_in = bits[i + 1];
      else bus.bit_valid = 1'b0;
      run_symbol(cur, i > 0, 1'b1, 0, SYM_CLKS);
      next_clk();
    end
    #1;
    check_idle("stream_end", 1'b1, 1'b1);
    check_val("stream_xfers", 32'(xfers - x0), 32'd4);
    next_clk();
  endtask

  initial begin
    int x0;
    rst           = 1'b1;
    en            = 1'b1;
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    repeat (3) next_clk();
    check_idle("reset", 1'b0, 1'b0);
    check_val("reset_strobe", 32'(sample_strobe), 32'd0);
    check_val("reset_xfers", 32'(xfers), 32'd0);

    // 1: single bit 0, then underrun
    rst           = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b1;
    #1;
    check_val("t1_idle_ready", 32'(bus.bit_ready), 32'd1);
    next_clk();
    bus.bit_valid = 1'b0;
    run_symbol(1'b0, 1'b0, 1'b1, 0, SYM_CLKS);
    next_clk(); #1;
    check_idle("t1_end", 1'b1, 1'b1);
    next_clk(); #1;
    check_val("t1_underrun_clear", 32'(underrun), 32'd0);

    // 2: single bit 1
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    next_clk();
    bus.bit_valid = 1'b0;
    run_symbol(1'b1, 1'b0, 1'b1, 0, SYM_CLKS);
    next_clk(); #1;
    check_idle("t2_end", 1'b1, 1'b1);
    check_val("t2_xfers", 32'(xfers), 32'd2);
    next_clk();

    // 3: stream 0,1,1,0 (bits[0] first)
    run_stream(4'b0110);

    // 4: en dropped at clock 50 with valid held
    x0            = xfers;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b1;
    next_clk();
    bus.bit_in = 1'b1;
    run_symbol(1'b0, 1'b0, 1'b0, 50, SYM_CLKS);
    next_clk(); #1;
    check_idle("t4_end", 1'b0, 1'b0);
    next_clk(); #1;
    check_idle("t4_stay", 1'b0, 1'b0);
    check_val("t4_xfers", 32'(xfers - x0), 32'd1);

    // 5: rst at clock 80, pending bit 0 must survive
    en            = 1'b1;
    x0            = xfers;
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    next_clk();
    bus.bit_in = 1'b0;
    run_symbol(1'b1, 1'b0, 1'b0, 0, 80);
    rst = 1'b1;
    next_clk(); #1;
    check_idle("t5_rst", 1'b0, 1'b0);
    check_val("t5_rst_strobe", 32'(sample_strobe), 32'd0);
    check_val("t5_rst_xfers", 32'(xfers - x0), 32'd1);
    rst = 1'b0;
    #1;
    check_val("t5_ready", 32'(bus.bit_ready), 32'd1);
    next_clk(); #1;
    check_val("t5_resume_xfers", 32'(xfers - x0), 32'd2);
    check_val("t5_resume_active", 32'(active), 32'd1);
    check_val("t5_resume_start", 32'(symbol_start), 32'd1);
    check_val("t5_resume_phase", 32'(phase), 32'd0);
    bus.bit_valid = 1'b0;
    rst = 1'b1;
    next_clk();
    rst = 1'b0;
    next_clk();

    // 6: stream 1,1,0,1 (bits[0] first); expected cur bits depend on encoding
    run_stream(4'b1011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpsk_phase_sequencer.md
Name: bpsk_phase_sequencer

Overview:
Drives the phase index into the sine wave table (combinational lookup, SINE_RESOLUTION entries) so that the table output forms a BPSK carrier. Accepts one data bit per symbol over a valid/ready handshake. For bit 1 it applies a half-table (180°) offset to the phase index. Sits between the bit source (framer/FIFO) and the wave table; the DAC path samples `signal` on `sample_strobe`.

Parameters:
- DATA_WIDTH, 12, width of phase index (matches wave table port).
- SINE_RESOLUTION, 20, table entries per carrier period; must be even and ≥ 2.
- CLK_PER_SAMPLE, 4, clocks per table step; must be ≥ 1.
- CYCLES_PER_BIT, 2, carrier periods per symbol; must be ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; deassertion stops gracefully at the next symbol boundary
- bit_in  in  1  data bit
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  sequencer accepts bit this cycle
- phase  out  DATA_WIDTH  index to wave table
- sample_strobe  out  1  one-clock pulse when phase advances
- symbol_start  out  1  one-clock pulse, first clock of each symbol
- active  out  1  symbol in progress
- underrun  out  1  one-clock pulse: symbol ended with en=1 but no bit available

Behaviour:
- Reset values:
  - state=IDLE, phase=0, bit_ready=0, sample_strobe=0, symbol_start=0, active=0, underrun=0.
  - Internal registers: div_cnt=0, idx=0, car_cnt=0, cur_bit=0.
- rst has priority over all other inputs. Asserting it mid-symbol aborts the symbol immediately. The bit being handed off in that cycle is not consumed.
- States:
  - IDLE:
    - phase=0, active=0.
    - bit_ready = en.
    - On bit_valid && bit_ready: latch cur_bit, clear idx/div_cnt/car_cnt, go to TX next clock.
  - TX:
    - active=1. symbol_start pulses on the first TX clock of each symbol.
    - div_cnt counts 0..CLK_PER_SAMPLE-1. A tick occurs when div_cnt==CLK_PER_SAMPLE-1. On a tick: sample_strobe=1 (registered, next clock) and idx advances.
    - idx wraps from SINE_RESOLUTION-1 to 0. On each wrap car_cnt increments.
    - Symbol end = tick with idx==SINE_RESOLUTION-1 and car_cnt==CYCLES_PER_BIT-1.
- Phase arithmetic:
  - phase = idx + (cur_bit ? SINE_RESOLUTION/2 : 0).
  - If the sum is ≥ SINE_RESOLUTION, subtract SINE_RESOLUTION.
  - Registered. phase is always < SINE_RESOLUTION. Zero-extend to DATA_WIDTH.
- Handshake:
  - bit_ready is asserted in IDLE (when en=1) and in the symbol-end clock of TX (when en=1). Deasserted otherwise.
  - Transfer = bit_valid && bit_ready in the same clock.
- Back-to-back symbols: a transfer on the symbol-end clock loads cur_bit. The next clock is symbol_start with idx=0, with no gap clock and phase continuous in time.
- Symbol end without a transfer:
  - en=1 and bit_valid=0: underrun pulses for 1 clock, go to IDLE.
  - en=0: go to IDLE with no underrun.
- en deasserted mid-symbol: the symbol completes fully.
- bit_valid held while bit_ready=0: the bit is ignored and is not latched.
- Latency:
  - Transfer in IDLE at clock N → TX at N+1 with phase=offset(cur_bit).
  - Symbol length = SINE_RESOLUTION*CYCLES_PER_BIT*CLK_PER_SAMPLE clocks.

Optional Feature:
- Macro: BPSK_DIFF_ENC_EN.
- Defined: differential BPSK.
  - Register prev_sym, reset 0, cleared on return to IDLE.
  - Loaded symbol is cur_bit = bit_in XOR prev_sym; prev_sym is updated to cur_bit on each transfer.
- Undefined: cur_bit = bit_in directly; no extra state.

Test Plan:
1. Reset, en=1, single transfer bit_in=0 → phase sequence 0,1,…,19,0,…,19. Each value is held 4 clocks. 160 clocks active. bit_ready=1 on clock 160. No bit offered → underrun pulse, then IDLE with phase=0.
2. Single bit_in=1 → phase starts at 10, runs 10..19,0..9 twice. After the final wrap the value is 9, then IDLE.
3. Stream 0,1,1,0 with bit_valid held high → symbol_start pulses exactly every 160 clocks. Phase jumps from 19 to 10 at the first boundary, 9 to 10 at the second, 9 to 0 at the third. Never an idle clock. 4 transfers total.
4. Drop en at clock 50 of a symbol with bit_valid=1 → symbol runs to clock 160. bit_ready stays 0. IDLE follows with no underrun and no new transfer.
5. rst asserted at clock 80 of a symbol → next clock all outputs at reset values. The pending bit is not consumed; it transfers after rst is released.
6. With BPSK_DIFF_ENC_EN, input 1,1,0,1 → cur_bit 1,0,0,1, giving start phases 10,0,0,10.
